note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Song-playback stage that sits directly upstream of the square-wave tone generator. Steps through a note list held in an external synchronous ROM and drives the generator's 7-bit tone index and enable. Each note is held for a programmable number of duration ticks, with optional articulation gap, rests, looping and stop control.

Parameters:
FREQ, 24000000, system clock frequency in Hz
TICK_HZ, 64, duration-tick rate in Hz; cycles per tick = FREQ/TICK_HZ (375000 at defaults)
ADDR_W, 6, ROM address width; song length max 2^ADDR_W words
GAP_TICKS, 1, articulation gap length in ticks (used only with ARTIC_GAP_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
play  in  1  start pulse; sampled only in IDLE
stop  in  1  abort playback; sampled every cycle
loop  in  1  level; at end of song restart from address 0 instead of finishing
rom_addr  out  ADDR_W  ROM read address
rom_data  in  16  ROM word, valid one cycle after rom_addr; [15] reserved, [14:8] tone, [7:0] duration in ticks
tone  out  7  tone index to the wave generator (0 = rest)
en  out  1  wave generator enable
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal song completion

Behaviour:
- Reset (rst=0, async): state=IDLE, rom_addr=0, tone=0, en=0, busy=0, done=0, tick divider=0, remaining=0.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, PLAY.
- IDLE: if play=1 and stop=0, set ptr=0 and go to FETCH. When stop=1, play is ignored.
- FETCH: rom_addr=ptr; go to LOAD next cycle. tone and en keep their previous values, so there is no glitch between notes.
- LOAD: capture rom_data.
  - If duration=0 (end marker): with loop=1, set ptr=0 and go to FETCH. With loop=0, set tone=0, en=0, pulse done, go to IDLE.
  - Otherwise: tone=data tone, en=(tone!=0), remaining=duration, tick divider cleared, go to PLAY.
- PLAY:
  - The divider counts 0..FREQ/TICK_HZ-1. At its terminal count, remaining decrements.
  - When remaining goes 1->0, ptr increments and the state goes to FETCH.
  - A note of duration D therefore occupies exactly D*(FREQ/TICK_HZ) cycles in PLAY.
- Address wrap: after the word at ptr=2^ADDR_W-1 completes, this is treated as an end marker (loop/done rules apply). ptr never wraps silently.
- stop=1 in any non-IDLE state: next edge sets IDLE, tone=0, en=0. No done pulse is generated. stop has priority over every other event.
- play while busy is ignored.
- loop is sampled only at the end-marker decision in LOAD.
- Rest note (tone=0): en=0 for the full duration; timing is identical to a sounding note.
- Divider width is 32 bits; remaining is 8 bits.
- FREQ/TICK_HZ must be >=2; otherwise the behaviour is undefined.

Optional Feature:
Macro ARTIC_GAP_EN.
- Defined: during PLAY, en is forced to 0 for the last GAP_TICKS ticks of each note, i.e. once remaining<=GAP_TICKS. If duration<=GAP_TICKS, no gap is applied and en stays high for the whole note. This separates repeated identical notes audibly.
- Undefined: en=(tone!=0) for the entire note. GAP_TICKS is unused.

Test Plan:
All scenarios use FREQ=640, TICK_HZ=64 (10 cycles/tick), ADDR_W=4, GAP_TICKS=1.
- Reset: assert rst=0 mid-PLAY -> tone=0, en=0, busy=0, done=0, rom_addr=0 immediately, with no clock edge needed.
- Single note: ROM[0]={tone 49, dur 3}, ROM[1]=end, play pulse at edge 0 -> tone=49/en=1 after edge 2, held 30 cycles. Then FETCH(addr 1), LOAD, done=1 for one cycle, en=0, busy=0. With ARTIC_GAP_EN defined, en falls 20 cycles after rising.
- Rest: ROM[0]={0,2}, ROM[1]={37,1}, ROM[2]=end -> en=0 for 20 PLAY cycles, then tone=37/en=1 for 10 cycles, then done.
- Loop and wrap: loop=1, ROM[0]={10,1}, ROM[1]=end -> tone 10 repeats every 14 cycles with no done pulse. A full 16-word ROM with no end marker returns to addr 0.
- Stop: stop=1 during the 2nd tick of a note -> next edge IDLE, en=0, tone=0, no done pulse. play+stop in the same cycle in IDLE -> remains IDLE.
- Busy ignore: a play pulse mid-song leaves rom_addr sequence and note timing unchanged.

Source files
------------

// File: rtl/note_sequencer.sv
// Song-playback sequencer: walks a note list in an external synchronous ROM and drives tone/en
// for the square-wave generator. Optional articulation gap enabled by defining ARTIC_GAP_EN.
module note_sequencer #(
  parameter int unsigned FREQ      = 24000000,
  parameter int unsigned TICK_HZ   = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        tone,
  output logic              en,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] TICK_LAST = 32'(FREQ / TICK_HZ) - 32'd1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr_nx;
  logic              wrap, wrap_nx;
  logic [6:0]        tone_nx;
  logic              en_nx, busy_nx, done_nx;
  logic [31:0]       div, div_nx;
  logic [7:0]        rem, rem_nx;
  logic              gap_ok, gap_ok_nx;

  logic unused_ok;
  assign unused_ok = &{1'b0, rom_data[15], GAP_TICKS[0], gap_ok};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      wrap     <= 1'b0;
      tone     <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div      <= '0;
      rem      <= '0;
      gap_ok   <= 1'b0;
    end else begin
      state    <= state_nx;
      rom_addr <= ptr_nx;
      wrap     <= wrap_nx;
      tone     <= tone_nx;
      en       <= en_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      div      <= div_nx;
      rem      <= rem_nx;
      gap_ok   <= gap_ok_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = rom_addr;
    wrap_nx   = wrap;
    tone_nx   = tone;
    en_nx     = en;
    done_nx   = 1'b0;
    div_nx    = div;
    rem_nx    = rem;
    gap_ok_nx = gap_ok;

    if (state != IDLE && stop) begin
      state_nx = IDLE;
      tone_nx  = '0;
      en_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (play && !stop) begin
            ptr_nx   = '0;
            wrap_nx  = 1'b0;
            state_nx = FETCH;
          end
        end
        FETCH: state_nx = LOAD;
        LOAD: begin
          // wrap marks that the last ROM word has been played; treat like an end marker
          if (wrap || rom_data[7:0] == 8'd0) begin
            if (loop) begin
              ptr_nx   = '0;
              wrap_nx  = 1'b0;
              state_nx = FETCH;
            end else begin
              tone_nx  = '0;
              en_nx    = 1'b0;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            tone_nx   = rom_data[14:8];
            en_nx     = (rom_data[14:8] != 7'd0);
            rem_nx    = rom_data[7:0];
            div_nx    = '0;
            gap_ok_nx = ({24'd0, rom_data[7:0]} > GAP_TICKS);
            state_nx  = PLAY;
          end
        end
        PLAY: begin
          if (div == TICK_LAST) begin
            div_nx = '0;
            rem_nx = rem - 8'd1;
            if (rem == 8'd1) begin
              if (&rom_addr) wrap_nx = 1'b1;
              ptr_nx   = rom_addr + ADDR_W'(1);
              state_nx = FETCH;
            end
`ifdef ARTIC_GAP_EN
            if (gap_ok && ({24'd0, rem_nx} <= GAP_TICKS)) en_nx = 1'b0;
`endif
          end else begin
            div_nx = div + 32'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: song vectors with an expected per-cycle output timeline held in a
// scoreboard queue, plus hand-written reset, stop and play-while-busy sequences.
module tb_note_sequencer;

  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [6:0]  tone;
  logic        en, busy, done;

  logic [15:0] rom [16];

  int errors = 0;
  int checks = 0;

  note_sequencer #(
    .FREQ(640), .TICK_HZ(64), .ADDR_W(4), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tone(tone), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [6:0] tone;
    logic       en;
    logic       busy;
    logic       done;
    logic       chk;
    logic [3:0] addr;
  } exp_t;

  typedef struct {
    logic [15:0][15:0] song;
    logic              lp;
    int                window;
    int                exp_done;
    int                mid;
    int                stop_at;
  } vec_t;

  exp_t exq[$];
  vec_t vecs[7];

  function automatic exp_t mk(logic [6:0] t, logic e, logic b, logic d, logic c, logic [3:0] a);
    mk = {t, e, b, d, c, a};
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Expected timeline: each note costs FETCH + LOAD + dur*10 cycles; end marker or running
  // past word 15 either restarts at address 0 (loop) or pulses done.
  task automatic build(input logic [15:0][15:0] song, input logic lp);
    int p, dur;
    logic [6:0] ct;
    logic ce, e;
    logic [15:0] w;
    bit fin;
    exq.delete();
    p = 0; ct = '0; ce = 1'b0; fin = 0;
    while (!fin && exq.size() < 400) begin
      exq.push_back(mk(ct, ce, 1'b1, 1'b0, 1'b1, 4'(p)));
      exq.push_back(mk(ct, ce, 1'b1, 1'b0, 1'b0, 4'd0));
      w = (p > 15) ? 16'd0 : song[p];
      dur = int'(w[7:0]);
      if (dur == 0) begin
        if (lp) p = 0;
        else begin
          exq.push_back(mk(7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
          for (int i = 0; i < 3; i++) exq.push_back(mk(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
          fin = 1;
        end
      end else begin
        ct = w[14:8];
        for (int c = 0; c < dur * 10; c++) begin
          e = (ct != 7'd0);
`ifdef ARTIC_GAP_EN
          if (dur > GAP && (dur - c / 10) <= GAP) e = 1'b0;
`endif
          exq.push_back(mk(ct, e, 1'b1, 1'b0, 1'b0, 4'd0));
          ce = e;
        end
        p++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n, first_done, seen;
    exp_t e;
    for (int i = 0; i < 16; i++) rom[i] = v.song[i];
    loop = v.lp;
    build(v.song, v.lp);
    n = (v.window < exq.size()) ? v.window : exq.size();
    if (v.stop_at >= 0 && v.stop_at + 1 < n) n = v.stop_at + 1;
    first_done = -1;
    @(negedge clk);
    play = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) play = 1'b0;
      if (v.mid > 0 && k == v.mid) play = 1'b1;
      if (v.mid > 0 && k == v.mid + 1) play = 1'b0;
      e = exq.pop_front();
      check($sformatf("v%0d_outs", id), k, 32'({tone, en, busy, done}), 32'({e.tone, e.en, e.busy, e.done}));
      if (e.chk) check($sformatf("v%0d_fetch_addr", id), k, 32'(rom_addr), 32'(e.addr));
      if (done && first_done < 0) first_done = k;
    end
    check($sformatf("v%0d_done_cycle", id), -1, 32'(first_done), 32'(v.exp_done));
    if (v.stop_at >= 0) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check($sformatf("v%0d_stop_outs", id), -1, 32'({tone, en, busy, done}), 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check($sformatf("v%0d_after_stop", id), -1, 32'(seen), 32'd0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 7; i++) begin
      vecs[i].song = '0; vecs[i].lp = 1'b0; vecs[i].window = 400;
      vecs[i].exp_done = -1; vecs[i].mid = 0; vecs[i].stop_at = -1;
    end
    // single note
    vecs[0].song[0] = {1'b0, 7'd49, 8'd3};
    vecs[0].exp_done = 34;
    // rest then note
    vecs[1].song[0] = {1'b0, 7'd0, 8'd2};
    vecs[1].song[1] = {1'b0, 7'd37, 8'd1};
    vecs[1].exp_done = 36;
    // looping single note
    vecs[2].song[0] = {1'b0, 7'd10, 8'd1};
    vecs[2].lp = 1'b1; vecs[2].window = 60;
    // full ROM, no end marker, looping
    for (int i = 0; i < 16; i++) vecs[3].song[i] = {1'b0, 7'(i + 1), 8'd1};
    vecs[3].lp = 1'b1; vecs[3].window = 220;
    // full ROM, no end marker, finishing
    for (int i = 0; i < 16; i++) vecs[4].song[i] = {1'b0, 7'(i + 1), 8'd1};
    vecs[4].exp_done = 194;
    // repeated identical notes with a play pulse while busy
    vecs[5].song[0] = {1'b0, 7'd5, 8'd2};
    vecs[5].song[1] = {1'b0, 7'd5, 8'd2};
    vecs[5].exp_done = 46; vecs[5].mid = 10;
    // stop during the second tick
    vecs[6].song[0] = {1'b0, 7'd49, 8'd3};
    vecs[6].stop_at = 14;

    for (int i = 0; i < 16; i++) rom[i] = 16'd0;

    #1;
    check("reset_outs", -1, 32'({rom_addr, tone, en, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outs", -1, 32'({rom_addr, tone, en, busy, done}), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // play and stop together in IDLE
    @(negedge clk);
    play = 1'b1; stop = 1'b1;
    @(negedge clk);
    play = 1'b0; stop = 1'b0;
    check("play_stop_idle", -1, 32'({tone, en, busy, done}), 32'd0);
    repeat (3) @(negedge clk);
    check("play_stop_idle_later", -1, 32'({busy, done}), 32'd0);

    // asynchronous reset in the middle of the second note
    for (int i = 0; i < 16; i++) rom[i] = 16'd0;
    rom[0] = {1'b0, 7'd0, 8'd2};
    rom[1] = {1'b0, 7'd37, 8'd1};
    @(negedge clk);
    play = 1'b1;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      play = 1'b0;
    end
    check("pre_reset_outs", -1, 32'({rom_addr, tone, en, busy}), 32'({4'd1, 7'd37, 1'b1, 1'b1}));
    #2 rst = 1'b0;
    #1 check("async_reset_outs", -1, 32'({rom_addr, tone, en, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", -1, 32'({tone, en, busy, done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
